// File: rtl/apb_pkg.sv
// Shared APB requester definitions: FSM state encoding and the default PPROT value.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb_req_wdog.sv
// ACCESS-phase watchdog: a down-counter reloaded whenever clear is high.
// expired is asserted on the CYCLES-th consecutive cycle with count_en high.
module apb_req_wdog #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload on clear, decrement while counting, park at terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD;
    end else if (count_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = count_en && !clear && (cnt_q == '0);

endmodule

// File: rtl/apb_requester.sv
// APB requester: accepts one command at a time, runs a SETUP/ACCESS transfer
// and presents a response until consumed.
// Optional ACCESS watchdog enabled by defining APB_REQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a command, bus idle
// SETUP  | PSEL=1, PENABLE=0 for one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY (or watchdog expiry)
// RESP   | response held until rsp_ready
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned STRB_W        = DATA_W / 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  input  logic [2:0]        cmd_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic [2:0]        PPROT,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic [STRB_W-1:0] PSTRB,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic [2:0]        prot_q, prot_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic              wdog_expired;

  // Next-state and command/response capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          // Reads never present byte strobes on the bus.
          strb_d  = cmd_write ? cmd_strb : '0;
          prot_d  = cmd_prot;
          write_d = cmd_write;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rdata_d   = write_q ? '0 : PRDATA;
          err_d     = PSLVERR;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (wdog_expired) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= PPROT_DEFAULT;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign rsp_valid = (state_q == RESP);
  assign PADDR     = addr_q;
  assign PPROT     = prot_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign PSTRB     = strb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef APB_REQ_TIMEOUT_EN
  apb_req_wdog #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (PCLK),
    .rst      (PRESET),
    .clear    (state_q != ACCESS),
    .count_en ((state_q == ACCESS) && !PREADY),
    .expired  (wdog_expired)
  );
  assign rsp_timeout = timeout_q;
`else
  // Without the watchdog ACCESS waits for PREADY forever.
  logic unused_cfg;
  assign wdog_expired = 1'b0;
  assign rsp_timeout  = 1'b0;
  assign unused_cfg   = timeout_q ^ (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_apb_requester.sv
module tb_apb_requester;

  localparam int TMO = 16;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [2:0]  PPROT;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]  PSTRB;

  int checks = 0;
  int errors = 0;

  apb_requester #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer. Called and returning at a falling edge.
  // waits: ACCESS cycles with PREADY low before the completer answers.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input int waits,
                         input logic [31:0] prdata, input bit slverr, input int rsp_delay,
                         input bit hold_valid);
    int exp_acc, n, psel_n, pen_n, acc;
    logic [31:0] exp_rdata, got_rdata;
    bit exp_err, exp_to, bus_ok, hold_ok;

    exp_acc   = waits + 1;
    exp_rdata = wr ? 32'h0 : prdata;
    exp_err   = slverr;
    exp_to    = 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
    if (waits >= TMO) begin
      exp_acc   = TMO;
      exp_rdata = 32'h0;
      exp_err   = 1'b1;
      exp_to    = 1'b1;
    end
`endif

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_strb = strb; cmd_prot = prot;
    @(posedge PCLK);
    @(negedge PCLK);
    if (hold_valid) begin
      cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
      cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end

    n = 0; psel_n = 0; pen_n = 0; acc = 0; bus_ok = 1'b1;
    while (!rsp_valid && n < 200) begin
      n++;
      if (PSEL) begin
        psel_n++;
        if (PENABLE) pen_n++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata || PPROT !== prot ||
            PSTRB !== (wr ? strb : 4'h0))
          bus_ok = 1'b0;
      end
      if (PSEL && PENABLE) begin
        if (acc == waits) begin
          PREADY = 1'b1; PRDATA = prdata; PSLVERR = slverr;
        end else begin
          PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        end
        acc++;
      end else begin
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
      @(negedge PCLK);
    end
    PREADY = 1'b0;

    check("rsp_latency", n, 1 + exp_acc);
    check("psel_cycles", psel_n, exp_acc + 1);
    check("penable_cycles", pen_n, exp_acc);
    check("bus_stable", bus_ok, 1);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_timeout", rsp_timeout, exp_to);
    check("psel_in_resp", PSEL, 0);

    got_rdata = rsp_rdata;
    hold_ok = 1'b1;
    for (int d = 0; d < rsp_delay; d++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b1 || rsp_rdata !== got_rdata || rsp_err !== exp_err ||
          cmd_ready !== 1'b0 || PSEL !== 1'b0 || PENABLE !== 1'b0)
        hold_ok = 1'b0;
    end
    if (rsp_delay > 0) check("rsp_hold", hold_ok, 1);

    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("back_idle_ready", cmd_ready, 1);
    check("back_idle_valid", rsp_valid, 0);
  endtask

  initial begin
    bit ok;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    #1;
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_bus", {PADDR, PWDATA}, 64'h0);
    check("rst_misc", {PSTRB, PPROT, PWRITE, rsp_err, rsp_timeout}, 0);
    check("rst_rdata", rsp_rdata, 0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);

    // zero-wait write
    run_txn(1'b1, 32'h0, 32'h20, 4'hF, 3'b000, 0, 32'h0, 1'b0, 0, 1'b0);
    // read with three wait states
    run_txn(1'b0, 32'h8000_0000, 32'h1234_5678, 4'hF, 3'b010, 3, 32'hA5, 1'b0, 0, 1'b0);
    // completer error on a write
    run_txn(1'b1, 32'h44, 32'hCAFE, 4'h3, 3'b001, 1, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
    // response back-pressure with a competing command offered
    run_txn(1'b0, 32'h100, 32'h0, 4'hA, 3'b111, 2, 32'h5A5A_1234, 1'b0, 5, 1'b1);

    for (int i = 0; i < 20; i++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
              int'($urandom_range(0, 5)), $urandom, 1'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    // leave non-zero response state behind, then reset mid-transfer
    run_txn(1'b0, 32'h200, 32'h0, 4'h0, 3'b101, 0, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h300; cmd_wdata = 32'h77;
    cmd_strb = 4'hF; cmd_prot = 3'b011;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1;
    check("arst_psel", PSEL, 0);
    check("arst_penable", PENABLE, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_bus", {PADDR, PWDATA, PSTRB, PPROT, PWRITE}, 0);
    check("arst_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 0);
    @(negedge PCLK);
    PRESET = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0 || cmd_ready !== 1'b1) ok = 1'b0;
    end
    check("post_rst_quiet", ok, 1);

    run_txn(1'b0, 32'h400, 32'h0, 4'hF, 3'b000, 1, 32'h0BAD_F00D, 1'b0, 0, 1'b0);

`ifdef APB_REQ_TIMEOUT_EN
    run_txn(1'b0, 32'h500, 32'h0, 4'hF, 3'b000, 1000, 32'h1111, 1'b0, 1, 1'b0);
    run_txn(1'b1, 32'h504, 32'h9, 4'h1, 3'b000, 2, 32'h0, 1'b0, 0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
